// File: rtl/layer_mixer.sv
// -----------------------------------------------------------------------------
// layer_mixer
//
// N-layer pixel compositor sitting between the VGA timing driver and the DAC.
// Each pixel takes the lowest-index layer that is both opaque and enabled.
// If no layer qualifies, the background colour is used. Blanking forces black.
// An optional frame-synchronous global fade then scales every channel.
// The syncs are delayed so that the DAC outputs and the syncs leave together.
//
// Optional feature macro: LAYER_MIXER_FADE_EN
//   defined   : fade FSM, frame counter and channel scaling are built.
//   undefined : stage 2 is a plain register, level reads 16, busy reads 0.
//
// Ports:
//   clk_vga        pixel clock
//   rst            asynchronous, active-high reset
//   layer_rgb_i    packed layer colours, layer k at [k*RGB_W +: RGB_W]
//   layer_alpha_i  per-layer opaque flag
//   layer_en_i     per-layer runtime enable mask
//   h_sync_i       horizontal sync from the timing driver (active-low)
//   v_sync_i       vertical sync from the timing driver (active-low)
//   disp_i         active-video flag from the timing driver
//   fade_req_i     single-cycle fade command strobe
//   fade_cmd_i     2'b01 fade out, 2'b10 fade in, other codes do nothing
//   vga_rgb_o      composited pixel {R,G,B}
//   h_sync_o       delayed h_sync, aligned with vga_rgb_o
//   v_sync_o       delayed v_sync, aligned with vga_rgb_o
//   disp_o         delayed disp, aligned with vga_rgb_o
//   fade_busy_o    a fade is in progress
//   fade_level_o   current brightness, 0..16
// -----------------------------------------------------------------------------
module layer_mixer #(
  parameter int               N_LAYERS         = 4,
  parameter int               RGB_W            = 12,
  parameter logic [RGB_W-1:0] BG_RGB           = 12'h024,
  parameter int               SYNC_LAT         = 2,
  parameter int               FADE_STEP_FRAMES = 4
) (
  input  logic                      clk_vga,
  input  logic                      rst,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb_i,
  input  logic [N_LAYERS-1:0]       layer_alpha_i,
  input  logic [N_LAYERS-1:0]       layer_en_i,
  input  logic                      h_sync_i,
  input  logic                      v_sync_i,
  input  logic                      disp_i,
  input  logic                      fade_req_i,
  input  logic [1:0]                fade_cmd_i,
  output logic [RGB_W-1:0]          vga_rgb_o,
  output logic                      h_sync_o,
  output logic                      v_sync_o,
  output logic                      disp_o,
  output logic                      fade_busy_o,
  output logic [4:0]                fade_level_o
);

  localparam int CW = RGB_W / 3;

  // Timing bundle {h_sync, v_sync, disp}. Reset value: syncs idle high, disp low.
  localparam logic [2:0] SYNC_RST = 3'b110;

  logic [2:0]       syncAl;
  logic [RGB_W-1:0] pix1_d;
  logic [RGB_W-1:0] pix1_q;
  logic [2:0]       sync1_q;
  logic [RGB_W-1:0] rgb_d;
  logic [RGB_W-1:0] rgb_q;
  logic [2:0]       sync2_q;
  logic [4:0]       level;

  // Delay line that moves the timing signals behind the sprite ROM read
  // latency. With zero latency the raw inputs are already aligned.
  generate
    if (SYNC_LAT == 0) begin : gNoDly
      assign syncAl = {h_sync_i, v_sync_i, disp_i};
    end else begin : gDly
      logic [2:0] dly_q [SYNC_LAT];

      always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_LAT; i++) dly_q[i] <= SYNC_RST;
        end else begin
          dly_q[0] <= {h_sync_i, v_sync_i, disp_i};
          for (int i = 1; i < SYNC_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign syncAl = dly_q[SYNC_LAT-1];
    end
  endgenerate

  // Layer select. The loop runs from the highest index down, so the last
  // qualifying assignment is the lowest index and wins priority.
  always_comb begin
    pix1_d = BG_RGB;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (layer_alpha_i[k] && layer_en_i[k]) pix1_d = layer_rgb_i[k*RGB_W +: RGB_W];
    end
    if (!syncAl[0]) pix1_d = '0;
  end

  // Stage 1 register: selected pixel plus the timing it belongs to.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      pix1_q  <= '0;
      sync1_q <= SYNC_RST;
    end else begin
      pix1_q  <= pix1_d;
      sync1_q <= syncAl;
    end
  end

`ifdef LAYER_MIXER_FADE_EN

  localparam int              CNTW      = $clog2(FADE_STEP_FRAMES + 1);
  localparam logic [CNTW-1:0] STEP_LAST = CNTW'(FADE_STEP_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} fadeState_t;

  fadeState_t      state_q;
  logic [CNTW-1:0] frameCnt_q;
  logic [4:0]      level_q;
  logic            busy_q;
  logic            vsPrev_q;
  logic            frameTick;

  // Frame tick is the falling edge of the raw v_sync. The history register
  // resets high so that a sync held low through reset does not fire a tick.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) vsPrev_q <= 1'b1;
    else     vsPrev_q <= v_sync_i;
  end

  assign frameTick = vsPrev_q & ~v_sync_i;

  // Fade controller. Requests are only taken in IDLE, so a tick on the same
  // cycle as an accepted request is not counted. Level moves only on tick
  // cycles, which keeps every brightness change on a frame boundary.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      frameCnt_q <= '0;
      level_q    <= 5'd16;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fade_req_i && (fade_cmd_i == 2'b01) && (level_q != 5'd0)) begin
            state_q    <= FADE_OUT;
            busy_q     <= 1'b1;
            frameCnt_q <= '0;
          end else if (fade_req_i && (fade_cmd_i == 2'b10) && (level_q != 5'd16)) begin
            state_q    <= FADE_IN;
            busy_q     <= 1'b1;
            frameCnt_q <= '0;
          end
        end
        FADE_OUT: begin
          if (frameTick) begin
            if (frameCnt_q == STEP_LAST) begin
              frameCnt_q <= '0;
              level_q    <= level_q - 5'd1;
              if (level_q == 5'd1) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              frameCnt_q <= frameCnt_q + CNTW'(1);
            end
          end
        end
        FADE_IN: begin
          if (frameTick) begin
            if (frameCnt_q == STEP_LAST) begin
              frameCnt_q <= '0;
              level_q    <= level_q + 5'd1;
              if (level_q == 5'd15) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              frameCnt_q <= frameCnt_q + CNTW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign level        = level_q;
  assign fade_level_o = level_q;
  assign fade_busy_o  = busy_q;

  // Channel scaling: (c * level) >> 4 at CW+5 bits, truncated back to CW.
  // Level 16 reproduces the channel exactly because c*16 >> 4 == c.
  always_comb begin
    rgb_d = '0;
    for (int c = 0; c < 3; c++) begin
      rgb_d[c*CW +: CW] = CW'(({5'b0, pix1_q[c*CW +: CW]} * {{CW{1'b0}}, level}) >> 4);
    end
  end

`else

  logic fadeCtrl_unused;

  assign fadeCtrl_unused = &{1'b0, fade_req_i, fade_cmd_i};
  assign level           = 5'd16;
  assign fade_level_o    = level;
  assign fade_busy_o     = 1'b0;

  // Without the fade, stage 2 only keeps the latency identical.
  always_comb begin
    rgb_d = pix1_q;
  end

`endif

  // Stage 2 register drives the DAC pins and the aligned syncs.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      rgb_q   <= '0;
      sync2_q <= SYNC_RST;
    end else begin
      rgb_q   <= rgb_d;
      sync2_q <= sync1_q;
    end
  end

  assign vga_rgb_o = rgb_q;
  assign h_sync_o  = sync2_q[2];
  assign v_sync_o  = sync2_q[1];
  assign disp_o    = sync2_q[0];

endmodule

// File: tb/tb_layer_mixer.sv
// -----------------------------------------------------------------------------
// tb_layer_mixer
//
// Directed bench for layer_mixer (N_LAYERS=4, RGB_W=12, SYNC_LAT=2,
// FADE_STEP_FRAMES=1). Inputs are driven and outputs are sampled on the
// falling clock edge, so a value applied at one falling edge appears on
// vga_rgb_o two falling edges later.
// -----------------------------------------------------------------------------
module tb_layer_mixer;

  logic        clk_vga = 1'b0;
  logic        rst;
  logic [47:0] layerRgb;
  logic [3:0]  layerAlpha;
  logic [3:0]  layerEn;
  logic        hSync;
  logic        vSync;
  logic        disp;
  logic        fadeReq;
  logic [1:0]  fadeCmd;
  logic [11:0] vgaRgb;
  logic        hSyncO;
  logic        vSyncO;
  logic        dispO;
  logic        fadeBusy;
  logic [4:0]  fadeLevel;

  int compared   = 0;
  int mismatched = 0;

  layer_mixer #(
    .N_LAYERS        (4),
    .RGB_W           (12),
    .BG_RGB          (12'h024),
    .SYNC_LAT        (2),
    .FADE_STEP_FRAMES(1)
  ) dut (
    .clk_vga      (clk_vga),
    .rst          (rst),
    .layer_rgb_i  (layerRgb),
    .layer_alpha_i(layerAlpha),
    .layer_en_i   (layerEn),
    .h_sync_i     (hSync),
    .v_sync_i     (vSync),
    .disp_i       (disp),
    .fade_req_i   (fadeReq),
    .fade_cmd_i   (fadeCmd),
    .vga_rgb_o    (vgaRgb),
    .h_sync_o     (hSyncO),
    .v_sync_o     (vSyncO),
    .disp_o       (dispO),
    .fade_busy_o  (fadeBusy),
    .fade_level_o (fadeLevel)
  );

  // Free-running pixel clock, 10 time units per period.
  always #5 clk_vga = ~clk_vga;

  // Comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Set layer qualifiers and disp, then let the given number of cycles pass.
  task automatic applyStimulus(input logic [3:0] alpha, input logic [3:0] en,
                               input logic dispVal, input int cycles);
    layerAlpha = alpha;
    layerEn    = en;
    disp       = dispVal;
    repeat (cycles) @(negedge clk_vga);
  endtask

  // One-cycle fade command strobe.
  task automatic fadeRequest(input logic [1:0] cmd);
    fadeReq = 1'b1;
    fadeCmd = cmd;
    @(negedge clk_vga);
    fadeReq = 1'b0;
    fadeCmd = 2'b00;
  endtask

  // One v_sync falling edge, i.e. one frame tick.
  task automatic frameTick();
    vSync = 1'b0;
    @(negedge clk_vga);
    vSync = 1'b1;
    @(negedge clk_vga);
  endtask

  initial begin
    rst        = 1'b1;
    layerRgb   = {12'hABC, 12'h0F0, 12'hF00, 12'h00F};
    layerAlpha = 4'b0000;
    layerEn    = 4'b0000;
    hSync      = 1'b1;
    vSync      = 1'b1;
    disp       = 1'b0;
    fadeReq    = 1'b0;
    fadeCmd    = 2'b00;

    // Reset state
    repeat (2) @(negedge clk_vga);
    checkOutput("rstRgb",   vgaRgb,    12'h000);
    checkOutput("rstDisp",  dispO,     1'b0);
    checkOutput("rstHs",    hSyncO,    1'b1);
    checkOutput("rstVs",    vSyncO,    1'b1);
    checkOutput("rstLevel", fadeLevel, 5'd16);
    checkOutput("rstBusy",  fadeBusy,  1'b0);
    rst = 1'b0;

    // Priority and mask
    applyStimulus(4'b0110, 4'b1111, 1'b1, 5);
    checkOutput("prioL1",   vgaRgb, 12'hF00);
    checkOutput("dispHigh", dispO,  1'b1);
    applyStimulus(4'b0110, 4'b1101, 1'b1, 2);
    checkOutput("maskL2", vgaRgb, 12'h0F0);

    // Background and blanking
    applyStimulus(4'b0000, 4'b1111, 1'b1, 2);
    checkOutput("bg", vgaRgb, 12'h024);
    applyStimulus(4'b1111, 4'b1111, 1'b0, 3);
    checkOutput("blankLateRgb",  vgaRgb, 12'h00F);
    checkOutput("blankLateDisp", dispO,  1'b1);
    applyStimulus(4'b1111, 4'b1111, 1'b0, 1);
    checkOutput("blankRgb",  vgaRgb, 12'h000);
    checkOutput("blankDisp", dispO,  1'b0);

    // Sync alignment: pulse low at t, output low only at t+4
    applyStimulus(4'b1111, 4'b1111, 1'b1, 5);
    hSync = 1'b0;
    @(negedge clk_vga);
    hSync = 1'b1;
    repeat (2) @(negedge clk_vga);
    checkOutput("hsT3", hSyncO, 1'b1);
    @(negedge clk_vga);
    checkOutput("hsT4", hSyncO, 1'b0);
    @(negedge clk_vga);
    checkOutput("hsT5", hSyncO, 1'b1);

    layerRgb[11:0] = 12'hFFF;
    applyStimulus(4'b0001, 4'b1111, 1'b1, 3);
    checkOutput("passFFF", vgaRgb, 12'hFFF);

`ifdef LAYER_MIXER_FADE_EN
    // Fade out
    fadeRequest(2'b01);
    checkOutput("outBusy",  fadeBusy,  1'b1);
    checkOutput("outLvl16", fadeLevel, 5'd16);
    frameTick();
    checkOutput("outLvl15", fadeLevel, 5'd15);
    checkOutput("outRgbE",  vgaRgb,    12'hEEE);

    // Fade-in request while busy is ignored
    fadeRequest(2'b10);
    frameTick();
    checkOutput("outLvl14", fadeLevel, 5'd14);
    checkOutput("outRgbD",  vgaRgb,    12'hDDD);
    repeat (13) frameTick();
    checkOutput("outLvl1",  fadeLevel, 5'd1);
    checkOutput("outBusy1", fadeBusy,  1'b1);

    // Final tick with a coinciding request that must be ignored
    vSync   = 1'b0;
    fadeReq = 1'b1;
    fadeCmd = 2'b10;
    @(negedge clk_vga);
    vSync   = 1'b1;
    fadeReq = 1'b0;
    fadeCmd = 2'b00;
    @(negedge clk_vga);
    checkOutput("outLvl0",  fadeLevel, 5'd0);
    checkOutput("outIdle",  fadeBusy,  1'b0);
    checkOutput("outBlack", vgaRgb,    12'h000);

    // Fade-out at level 0 and the 11 code do nothing
    fadeRequest(2'b01);
    checkOutput("zeroBusy", fadeBusy, 1'b0);
    frameTick();
    checkOutput("zeroLvl", fadeLevel, 5'd0);
    fadeRequest(2'b11);
    checkOutput("cmd11Busy", fadeBusy, 1'b0);

    // Fade-in accepted on a tick cycle; that tick is not counted
    vSync   = 1'b0;
    fadeReq = 1'b1;
    fadeCmd = 2'b10;
    @(negedge clk_vga);
    vSync   = 1'b1;
    fadeReq = 1'b0;
    fadeCmd = 2'b00;
    @(negedge clk_vga);
    checkOutput("inBusy", fadeBusy,  1'b1);
    checkOutput("inLvl0", fadeLevel, 5'd0);
    repeat (7) frameTick();
    checkOutput("inLvl7", fadeLevel, 5'd7);
    checkOutput("inRgb7", vgaRgb,    12'h666);

    // Reset mid-fade
    rst = 1'b1;
    #1;
    checkOutput("midRstLvl",  fadeLevel, 5'd16);
    checkOutput("midRstBusy", fadeBusy,  1'b0);
    checkOutput("midRstRgb",  vgaRgb,    12'h000);
    checkOutput("midRstDisp", dispO,     1'b0);
    repeat (2) @(negedge clk_vga);
    checkOutput("midRstHold", vgaRgb, 12'h000);
    rst = 1'b0;
    applyStimulus(4'b0001, 4'b1111, 1'b1, 5);
    checkOutput("postRstRgb", vgaRgb,   12'hFFF);
    checkOutput("postRstBusy", fadeBusy, 1'b0);
`else
    // Fade hardware absent: commands and ticks leave brightness alone
    fadeRequest(2'b01);
    checkOutput("noFadeBusy", fadeBusy,  1'b0);
    checkOutput("noFadeLvl",  fadeLevel, 5'd16);
    repeat (2) frameTick();
    checkOutput("noFadeLvl2", fadeLevel, 5'd16);
    checkOutput("noFadeRgb",  vgaRgb,    12'hFFF);

    rst = 1'b1;
    #1;
    checkOutput("rst2Rgb",  vgaRgb, 12'h000);
    checkOutput("rst2Disp", dispO,  1'b0);
    repeat (2) @(negedge clk_vga);
    rst = 1'b0;
    applyStimulus(4'b0001, 4'b1111, 1'b1, 5);
    checkOutput("postRstRgb", vgaRgb, 12'hFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
